// File: rtl/frame_pkg.sv
// frame_pkg: shared constants and state encoding for the sender frame scheduler.
// Frame geometry: ROWS rows of COLS columns; columns [0, OH_COLS) carry overhead,
// [OH_COLS, OH_COLS+PYLD_COLS) carry client payload and the last column is the trailer.
package frame_pkg;

  localparam int ROWS      = 4;
  localparam int COLS      = 1041;
  localparam int OH_COLS   = 16;
  localparam int PYLD_COLS = 1024;
  localparam int LVL_W     = 12;

  localparam int ROW_W = 2;
  localparam int COL_W = 11;

  localparam logic [COL_W-1:0] PYLD_FIRST_COL = COL_W'(OH_COLS);
  localparam logic [COL_W-1:0] PYLD_LAST_COL  = COL_W'(OH_COLS + PYLD_COLS - 1);
  localparam logic [COL_W-1:0] LAST_COL       = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0] LAST_ROW       = ROW_W'(ROWS - 1);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_ROW = 2'd1,
    ST_RUN      = 2'd2
  } state_e;

  // True when the column carries client payload (and therefore needs a FIFO read).
  function automatic logic is_pyld_col(input logic [COL_W-1:0] col);
    return (col >= PYLD_FIRST_COL) && (col <= PYLD_LAST_COL);
  endfunction

endpackage

// File: rtl/frame_pos_counter.sv
// frame_pos_counter: row/column position counter for one frame.
// Ports:
//   i_clk, i_rst   clock, asynchronous active-high reset
//   i_adv          advance one column this cycle
//   o_row, o_col   current position
//   o_row_end      current column is the trailer (last column of the row)
//   o_frame_end    current position is the last column of the last row
module frame_pos_counter
  import frame_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_adv,
  output logic [ROW_W-1:0] o_row,
  output logic [COL_W-1:0] o_col,
  output logic             o_row_end,
  output logic             o_frame_end
);

  logic [ROW_W-1:0] row_q, row_d;
  logic [COL_W-1:0] col_q, col_d;

  assign o_row_end   = (col_q == LAST_COL);
  assign o_frame_end = o_row_end && (row_q == LAST_ROW);
  assign o_row       = row_q;
  assign o_col       = col_q;

  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (i_adv) begin
      if (o_row_end) begin
        col_d = '0;
        row_d = o_frame_end ? '0 : row_q + ROW_W'(1);
      end else begin
        col_d = col_q + COL_W'(1);
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      row_q <= '0;
      col_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end

endmodule

// File: rtl/frame_scheduler.sv
// frame_scheduler: sequences the sender frame mapper.
// Walks the frame position one column per cycle, issues payload FIFO reads on
// payload columns and presents the position one cycle later, aligned with the
// FIFO's registered read data. A row only starts once the FIFO already holds a
// full row of payload, so a row is never interrupted.
// Ports:
//   i_clk, i_rst        clock, asynchronous active-high reset
//   i_tx_en             transmit enable, looked at only between frames
//   i_clr_err           clears the sticky underrun flag
//   i_fifo_level        payload FIFO occupancy in bytes
//   i_fifo_empty        payload FIFO empty
//   o_fifo_rd           FIFO read strobe (combinational, issue cycle)
//   o_enable            frame controller enable (registered)
//   o_row_cnt/o_col_cnt position for the frame controller (registered, hold when idle)
//   o_pyld_valid        FIFO data on the bus is valid payload
//   o_frame_start       pulse with row 0 / col 0
//   o_frame_cnt         completed frames, wraps
//   o_underrun          sticky: a payload column found the FIFO empty
module frame_scheduler
  import frame_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_tx_en,
  input  logic             i_clr_err,
  input  logic [LVL_W-1:0] i_fifo_level,
  input  logic             i_fifo_empty,
  output logic             o_fifo_rd,
  output logic             o_enable,
  output logic [ROW_W-1:0] o_row_cnt,
  output logic [COL_W-1:0] o_col_cnt,
  output logic             o_pyld_valid,
  output logic             o_frame_start,
  output logic [15:0]      o_frame_cnt,
  output logic             o_underrun
);

  state_e state_q, state_d;

  logic [ROW_W-1:0] row_pos;
  logic [COL_W-1:0] col_pos;
  logic             row_end;
  logic             frame_end;
  logic             issue;
  logic             pyld_col;
  logic             row_ready;

  logic             enable_q;
  logic [ROW_W-1:0] row_cnt_q;
  logic [COL_W-1:0] col_cnt_q;
  logic             pyld_valid_q;
  logic             frame_start_q;
  logic [15:0]      frame_cnt_q;
  logic             underrun_q;

  assign issue     = (state_q == ST_RUN);
  assign pyld_col  = is_pyld_col(col_pos);
  assign row_ready = (i_fifo_level >= LVL_W'(PYLD_COLS));

  frame_pos_counter u_pos (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_adv       (issue),
    .o_row       (row_pos),
    .o_col       (col_pos),
    .o_row_end   (row_end),
    .o_frame_end (frame_end)
  );

  // Next-state logic. Every row passes through WAIT_ROW so the level check
  // is always made fresh at row start.
  always_comb begin
    state_d   = state_q;
    o_fifo_rd = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (i_tx_en) state_d = ST_WAIT_ROW;
      end
      ST_WAIT_ROW: begin
        if (row_ready) state_d = ST_RUN;
      end
      ST_RUN: begin
        o_fifo_rd = pyld_col && !i_fifo_empty;
        if (row_end) begin
          if (frame_end && !i_tx_en) state_d = ST_IDLE;
          else                       state_d = ST_WAIT_ROW;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Output stage: one cycle behind the issue so the position lines up with
  // the FIFO read data. Position registers hold while nothing is issued.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      enable_q      <= 1'b0;
      row_cnt_q     <= '0;
      col_cnt_q     <= '0;
      pyld_valid_q  <= 1'b0;
      frame_start_q <= 1'b0;
      frame_cnt_q   <= '0;
      underrun_q    <= 1'b0;
    end else begin
      enable_q      <= issue;
      pyld_valid_q  <= o_fifo_rd;
      frame_start_q <= issue && (row_pos == '0) && (col_pos == '0);
      if (issue) begin
        row_cnt_q <= row_pos;
        col_cnt_q <= col_pos;
      end
      if (issue && frame_end) frame_cnt_q <= frame_cnt_q + 16'd1;
      // Setting wins over a simultaneous clear so no underrun event is lost.
      if (issue && pyld_col && i_fifo_empty) underrun_q <= 1'b1;
      else if (i_clr_err)                    underrun_q <= 1'b0;
    end
  end

  assign o_enable      = enable_q;
  assign o_row_cnt     = row_cnt_q;
  assign o_col_cnt     = col_cnt_q;
  assign o_pyld_valid  = pyld_valid_q;
  assign o_frame_start = frame_start_q;
  assign o_frame_cnt   = frame_cnt_q;
  assign o_underrun    = underrun_q;

endmodule

// File: tb/tb_frame_scheduler.sv
// Directed bench for frame_scheduler with a position scoreboard: the expected
// (row, col, payload-valid, frame-start) sequence of a frame is queued before
// the frame is started and popped on every cycle the DUT shows o_enable.
module tb_frame_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        tx_en;
  logic        clr_err;
  logic [11:0] fifo_level;
  logic        fifo_empty;
  logic        fifo_rd;
  logic        enable;
  logic [1:0]  row_cnt;
  logic [10:0] col_cnt;
  logic        pyld_valid;
  logic        frame_start;
  logic [15:0] frame_cnt;
  logic        underrun;

  typedef struct packed {
    logic [1:0]  row;
    logic [10:0] col;
    logic        pv;
    logic        fs;
  } pos_t;

  pos_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   en_cnt = 0;
  int   rd_cnt = 0;
  int   fs_cnt = 0;

  always #5 clk = ~clk;

  frame_scheduler dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_tx_en       (tx_en),
    .i_clr_err     (clr_err),
    .i_fifo_level  (fifo_level),
    .i_fifo_empty  (fifo_empty),
    .o_fifo_rd     (fifo_rd),
    .o_enable      (enable),
    .o_row_cnt     (row_cnt),
    .o_col_cnt     (col_cnt),
    .o_pyld_valid  (pyld_valid),
    .o_frame_start (frame_start),
    .o_frame_cnt   (frame_cnt),
    .o_underrun    (underrun)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Queue one frame worth of expected positions; (ur_row, ur_col) is the
  // column where the FIFO will be forced empty (-1 for none).
  task automatic push_frame(input int ur_row, input int ur_col);
    pos_t e;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 1041; c++) begin
        e.row = 2'(r);
        e.col = 11'(c);
        e.pv  = (c >= 16) && (c < 1040) && !((r == ur_row) && (c == ur_col));
        e.fs  = (r == 0) && (c == 0);
        sb.push_back(e);
      end
    end
  endtask

  // Advance to the next falling edge and score whatever the DUT shows there.
  task automatic tick();
    pos_t e;
    @(negedge clk);
    if (fifo_rd === 1'b1)     rd_cnt++;
    if (frame_start === 1'b1) fs_cnt++;
    if (enable === 1'b1) begin
      en_cnt++;
      total++;
      if (sb.size() == 0) begin
        bad++;
        $error("FAIL sb_empty: observed=row%0d/col%0d expected=no output", row_cnt, col_cnt);
      end else begin
        e = sb.pop_front();
        assert ({row_cnt, col_cnt, pyld_valid, frame_start} === e) else begin
          bad++;
          $error("FAIL pos: observed=r%0d c%0d pv%0d fs%0d expected=r%0d c%0d pv%0d fs%0d",
                 row_cnt, col_cnt, pyld_valid, frame_start, e.row, e.col, e.pv, e.fs);
        end
      end
    end
  endtask

  task automatic wait_pos(input string tag, input int r, input int c, input int budget);
    int n = 0;
    tick();
    while (!(enable === 1'b1 && row_cnt == 2'(r) && col_cnt == 11'(c)) && n < budget) begin
      tick();
      n++;
    end
    if (n >= budget) check({tag, "_timeout"}, 32'(n), 32'(budget - 1));
  endtask

  task automatic wait_frames(input string tag, input int target, input int budget);
    int n = 0;
    while (frame_cnt !== 16'(target) && n < budget) begin
      tick();
      n++;
    end
    check(tag, 32'(frame_cnt), 32'(target));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_en"}, 32'(enable), 0);
    check({tag, "_rowcol"}, {19'd0, row_cnt, col_cnt}, 0);
    check({tag, "_pv_fs_rd"}, {29'd0, pyld_valid, frame_start, fifo_rd}, 0);
    check({tag, "_fcnt"}, 32'(frame_cnt), 0);
    check({tag, "_ur"}, 32'(underrun), 0);
  endtask

  initial begin
    int e0, r0, f0;
    rst = 1'b1; tx_en = 1'b0; clr_err = 1'b0; fifo_level = 12'd2000; fifo_empty = 1'b0;
    #1;
    check_all_zero("reset");
    repeat (3) tick();
    rst = 1'b0;
    repeat (5) tick();
    check("idle_no_enable", 32'(en_cnt), 0);
    $display("step reset: outputs checked");

    // Full frame with tx_en dropped as soon as the frame has started.
    push_frame(-1, -1);
    e0 = en_cnt; r0 = rd_cnt;
    tx_en = 1'b1;
    wait_pos("full_start", 0, 0, 20);
    tx_en = 1'b0;
    wait_frames("full_fcnt", 1, 6000);
    repeat (50) tick();
    check("full_enables", 32'(en_cnt - e0), 4164);
    check("full_reads", 32'(rd_cnt - r0), 4096);
    check("full_sb_drained", 32'(sb.size()), 0);
    $display("step full_frame: enables=%0d reads=%0d", en_cnt - e0, rd_cnt - r0);

    // Row gate: one byte short of a row keeps the scheduler waiting.
    push_frame(2, 500);
    e0 = en_cnt; r0 = rd_cnt; f0 = fs_cnt;
    fifo_level = 12'd1023;
    tx_en = 1'b1;
    repeat (100) tick();
    check("gate_held", 32'(en_cnt - e0), 0);
    fifo_level = 12'd1024;
    tick();
    check("gate_run_no_out", 32'(enable), 0);
    tick();
    check("gate_first_en", 32'(enable), 1);
    check("gate_first_col", 32'(col_cnt), 0);
    fifo_level = 12'd2000;
    $display("step row_gate: first column after level reached row size");

    // tx_en drop mid-frame: the frame must still finish.
    wait_pos("drop_pos", 1, 300, 2000);
    tx_en = 1'b0;
    $display("step tx_en_drop: at row 1 col 300");

    // Underrun: the issue following o_col_cnt=499 of row 2 is column 500.
    wait_pos("ur_pos", 2, 499, 3000);
    check("ur_before", 32'(underrun), 0);
    fifo_empty = 1'b1;
    #1;
    check("ur_no_read", 32'(fifo_rd), 0);
    tick();
    fifo_empty = 1'b0;
    check("ur_col", 32'(col_cnt), 500);
    check("ur_set", 32'(underrun), 1);
    wait_frames("drop_fcnt", 2, 3000);
    repeat (2000) tick();
    check("drop_enables", 32'(en_cnt - e0), 4164);
    check("ur_reads", 32'(rd_cnt - r0), 4095);
    check("drop_one_start", 32'(fs_cnt - f0), 1);
    check("ur_held", 32'(underrun), 1);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    check("ur_cleared", 32'(underrun), 0);
    check("drop_sb_drained", 32'(sb.size()), 0);
    $display("step underrun: flag set, held and cleared");

    // Reset in the middle of payload, then a clean frame.
    push_frame(-1, -1);
    tx_en = 1'b1;
    wait_pos("rst_pos", 2, 700, 4000);
    #2 rst = 1'b1;
    #1;
    check_all_zero("midrst");
    sb.delete();
    tick();
    tick();
    rst = 1'b0;
    push_frame(-1, -1);
    e0 = en_cnt;
    wait_pos("rst_restart", 0, 0, 20);
    check("rst_restart_fs", 32'(frame_start), 1);
    tx_en = 1'b0;
    wait_frames("rst_fcnt", 1, 6000);
    repeat (20) tick();
    check("rst_enables", 32'(en_cnt - e0), 4164);
    check("rst_sb_drained", 32'(sb.size()), 0);
    $display("step reset_mid_payload: restarted at row 0 col 0");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
